// File: rtl/uv_sum_queue.sv
// Circular FIFO of truncated u+v sums with a saturating count of pushed sums equal to one.
// Define UV_SUM_QUEUE_ASSERT_EN to elaborate the structural invariant assertions.
module uv_sum_queue #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_u,
  input  logic [WIDTH-1:0] in_v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] ones_seen
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ones_q, ones_d;

  logic             full, empty, push, pop;
  logic [WIDTH-1:0] sum;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // Carry out of the add is intentionally dropped.
  assign sum       = in_u + in_v;
  assign out_sum   = mem_q[rd_ptr_q];
  assign ones_seen = ones_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ones_d   = ones_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (push && (sum == WIDTH'(1)) && (ones_q != {WIDTH{1'b1}}))
      ones_d = ones_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ones_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ones_q   <= ones_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is cleared.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= sum;
  end

`ifdef UV_SUM_QUEUE_ASSERT_EN
  logic [WIDTH-1:0] ones_prev_q;
  logic             rst_prev_q;
  logic             chk_en_q;

  always_ff @(posedge clk) begin
    ones_prev_q <= ones_q;
    rst_prev_q  <= rst;
    if (rst) chk_en_q <= 1'b1;
  end

  // Checks are held off until the first reset has defined the state.
  always @* begin
    if (chk_en_q === 1'b1 && !rst) begin
      prop_count: assert (count_q <= CW'(DEPTH));
      prop_ptr:   assert (wr_ptr_q == PW'(rd_ptr_q + count_q[PW-1:0]));
      prop_full:  assert (!full || !in_ready);
      prop_empty: assert (!empty || !out_valid);
      prop_sat:   assert (rst_prev_q !== 1'b0 || ones_q >= ones_prev_q);
    end
  end
`endif

endmodule

// File: tb/tb_uv_sum_queue.sv
// Directed bench for uv_sum_queue (WIDTH=2, DEPTH=4) with hand-computed expectations.
module tb_uv_sum_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_u;
  logic [1:0] in_v;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sum;
  logic [1:0] ones_seen;

  int tests_run = 0;
  int tests_failed = 0;

  uv_sum_queue #(.WIDTH(2), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_u      (in_u),
    .in_v      (in_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .ones_seen (ones_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] u, input logic [1:0] v);
    in_valid = 1'b1;
    in_u = u;
    in_v = v;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_u = '0; in_v = '0;
    tick(); tick();
    rst = 1'b0;

    // reset then idle
    for (int i = 0; i < 3; i++) begin
      chk("idle_in_ready", 8'(in_ready), 8'd1);
      chk("idle_out_valid", 8'(out_valid), 8'd0);
      chk("idle_ones", 8'(ones_seen), 8'd0);
      tick();
    end

    // single push, one-cycle latency
    push(2'd1, 2'd2);
    chk("p1_out_valid", 8'(out_valid), 8'd1);
    chk("p1_out_sum", 8'(out_sum), 8'd3);
    chk("p1_in_ready", 8'(in_ready), 8'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("p1_drained", 8'(out_valid), 8'd0);

    // fill to full; truncation and ones counting
    push(2'd1, 2'd0);
    chk("f1_ones", 8'(ones_seen), 8'd1);
    push(2'd2, 2'd3);
    chk("f2_ones", 8'(ones_seen), 8'd2);
    push(2'd3, 2'd3);
    chk("f3_in_ready", 8'(in_ready), 8'd1);
    push(2'd0, 2'd1);
    chk("f4_in_ready", 8'(in_ready), 8'd0);
    chk("f4_ones", 8'(ones_seen), 8'd3);
    push(2'd1, 2'd1);
    chk("f5_in_ready", 8'(in_ready), 8'd0);
    chk("f5_head", 8'(out_sum), 8'd1);
    out_ready = 1'b1;
    chk("d1", 8'(out_sum), 8'd1); tick();
    chk("d2", 8'(out_sum), 8'd1); tick();
    chk("d3", 8'(out_sum), 8'd2); tick();
    chk("d4", 8'(out_sum), 8'd1); tick();
    chk("d_empty", 8'(out_valid), 8'd0);
    chk("d_ones", 8'(ones_seen), 8'd3);
    out_ready = 1'b0;

    // full with simultaneous push request and pop: pop only
    push(2'd2, 2'd0);
    push(2'd0, 2'd3);
    push(2'd2, 2'd2);
    push(2'd3, 2'd2);
    chk("g_full", 8'(in_ready), 8'd0);
    in_valid = 1'b1; in_u = 2'd1; in_v = 2'd0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("g_in_ready", 8'(in_ready), 8'd1);
    chk("g_head", 8'(out_sum), 8'd3); tick();
    chk("g_d2", 8'(out_sum), 8'd0); tick();
    chk("g_d3", 8'(out_sum), 8'd1); tick();
    chk("g_empty", 8'(out_valid), 8'd0);
    out_ready = 1'b0;

    // continuous stream with wraparound and saturation
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s_reset_ones", 8'(ones_seen), 8'd0);
    in_valid = 1'b1; in_u = 2'd0; in_v = 2'd1; out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("s_out_valid", 8'(out_valid), 8'd1);
      chk("s_out_sum", 8'(out_sum), 8'd1);
      chk("s_in_ready", 8'(in_ready), 8'd1);
      chk("s_ones", 8'(ones_seen), (k < 3) ? 8'(k) : 8'd3);
    end
    in_valid = 1'b0;
    tick();
    chk("s_empty", 8'(out_valid), 8'd0);
    out_ready = 1'b0;

    // reset mid-stream with count=2
    push(2'd1, 2'd1);
    push(2'd1, 2'd1);
    chk("r_head", 8'(out_sum), 8'd2);
    rst = 1'b1; in_valid = 1'b1; in_u = 2'd0; in_v = 2'd1; out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("r_out_valid", 8'(out_valid), 8'd0);
    chk("r_in_ready", 8'(in_ready), 8'd1);
    chk("r_ones", 8'(ones_seen), 8'd0);
    tick();
    chk("r_still_empty", 8'(out_valid), 8'd0);
    push(2'd3, 2'd1);
    chk("r_push_sum", 8'(out_sum), 8'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("r_final_empty", 8'(out_valid), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uv_sum_queue.md
# uv_sum_queue

Downstream consumer for the u/v counter-pair sample. Accepts (u, v) pairs over a valid/ready handshake, stores the truncated sum u+v in a small circular FIFO, and drains sums over a second valid/ready handshake. It also keeps a saturating count of stored sums equal to one. The block is a model-checking sample, so its structural invariants are written as immediate assertions that the prover checks.

## Interface
- WIDTH, 2, width of u, v and every stored sum
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  reset; synchronous and active-high
- in_valid  input  1  upstream pair valid
- in_ready  output  1  queue can accept a pair; equals !full
- in_u  input  WIDTH  u operand
- in_v  input  WIDTH  v operand
- out_valid  output  1  queue holds at least one sum; equals count != 0
- out_ready  input  1  downstream accepts the head sum
- out_sum  output  WIDTH  head-of-queue sum, read combinationally from mem[rd_ptr]
- ones_seen  output  WIDTH  saturating count of pushed sums equal to 1

## Operation
- Pointers: rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Flags: full = (count == DEPTH), empty = (count == 0).
- Push: push = in_valid & in_ready.
  - mem[wr_ptr] <= (in_u + in_v) truncated to WIDTH bits; the carry is discarded.
  - Then wr_ptr increments.
- Pop: pop = out_valid & out_ready; rd_ptr increments.
- Count update:
  - push & !pop: count +1
  - pop & !push: count -1
  - both or neither: count unchanged
- Full:
  - in_ready is 0, so no push happens.
  - A pop in the same cycle does not free the slot for a same-cycle push; there is no bypass.
- Empty:
  - out_valid is 0, so no pop happens, even when out_ready is 1.
  - There is no fall-through from in_* to out_sum.
- ones_seen:
  - Increments on every push whose truncated sum equals 1.
  - Saturates at 2^WIDTH-1 and never wraps.
- Contents of mem are not reset. out_sum is don't-care whenever out_valid is 0.
- Reset takes priority over push and pop in the same cycle. A reset mid-stream discards all queued entries.

## Timing
- After reset: rd_ptr=0, wr_ptr=0, count=0, ones_seen=0.
- Output values after reset: in_ready=1, out_valid=0.
- Latency: a push in cycle N gives out_valid=1 and out_sum equal to that sum in cycle N+1.
- Flags update in the cycle after the handshake. Both in_ready and out_valid are pure functions of registered count.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.
- Handshake rules:
  - Upstream may change in_u/in_v freely while in_ready=0.
  - Downstream may deassert out_ready at any time; the head entry is held.

## Configuration
- UV_SUM_QUEUE_ASSERT_EN defined: the block compiles an always @* block with these labelled immediate assertions:
  - prop_count: count <= DEPTH
  - prop_ptr: wr_ptr == rd_ptr + count[$clog2(DEPTH)-1:0] (mod DEPTH)
  - prop_full: full -> !in_ready
  - prop_empty: empty -> !out_valid
  - prop_sat: ones_seen never decreases except on rst
- UV_SUM_QUEUE_ASSERT_EN undefined: no assertions and no assertion-only logic are elaborated. Port behaviour is identical in both builds.

## Test plan
- Reset, then idle 3 cycles -> in_ready=1, out_valid=0, ones_seen=0 throughout.
- Push (u=1, v=2), out_ready=0 -> next cycle out_valid=1, out_sum=3, count=1.
- Push the four pairs (1,0), (2,3), (3,3), (0,1) with out_ready=0 (DEPTH=4):
  - after the fourth push, in_ready=0;
  - a fifth in_valid is ignored;
  - draining gives 1, 1, 2, 1 in order (2+3=5 and 3+3=6 truncate to 1 and 2), which confirms truncation;
  - ones_seen=3.
- Full queue, in_valid=1 and out_ready=1 in the same cycle -> only the pop occurs, count goes 4→3, and in_ready=1 next cycle.
- Ten continuous pushes of (0,1) with out_ready=1 -> pointers wrap twice, output order is preserved, and ones_seen saturates at 3.
- Assert rst with count=2 while pushing and popping -> next cycle count=0, out_valid=0, ones_seen=0. With UV_SUM_QUEUE_ASSERT_EN defined, no assertion fires.
